// File: rtl/ppu_mmio_regs_pkg.sv
// Shared definitions for the PPU MMIO register window and OAM DMA engine.
package ppu_pkg;

  localparam logic [15:0] ADDR_LCDC = 16'hFF40;
  localparam logic [15:0] ADDR_STAT = 16'hFF41;
  localparam logic [15:0] ADDR_SCY  = 16'hFF42;
  localparam logic [15:0] ADDR_SCX  = 16'hFF43;
  localparam logic [15:0] ADDR_LY   = 16'hFF44;
  localparam logic [15:0] ADDR_LYC  = 16'hFF45;
  localparam logic [15:0] ADDR_DMA  = 16'hFF46;
  localparam logic [15:0] ADDR_BGP  = 16'hFF47;
  localparam logic [15:0] ADDR_OBP0 = 16'hFF48;
  localparam logic [15:0] ADDR_OBP1 = 16'hFF49;
  localparam logic [15:0] ADDR_WY   = 16'hFF4A;
  localparam logic [15:0] ADDR_WX   = 16'hFF4B;

  localparam logic [7:0] RST_LCDC = 8'h91;
  localparam logic [7:0] RST_BGP  = 8'hFC;
  localparam logic [7:0] RST_REG  = 8'h00;
  localparam logic [7:0] RST_DOUT = 8'hFF;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    TRANSFER = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_READ  = 2'd1,
    DMA_WRITE = 2'd2
  } dma_state_t;

endpackage

// File: rtl/ppu_mmio_regs_if.sv
// CPU-side MMIO bus into the PPU register window.
interface ppu_mmio_regs_if;
  logic [15:0] mmio_a;
  logic [7:0]  mmio_din;
  logic        mmio_wr;
  logic [7:0]  mmio_dout;

  modport master (output mmio_a, output mmio_din, output mmio_wr, input mmio_dout);
  modport slave  (input mmio_a, input mmio_din, input mmio_wr, output mmio_dout);
endinterface

// File: rtl/ppu_mmio_regs_oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from page<<8 into OAM, one byte
// every DMA_STRIDE clocks (one read clock, one write clock, then idle).
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int DMA_STRIDE = 4,
  parameter int DMA_LEN    = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  src_page,
  input  logic [7:0]  dma_src_din,
  output logic        dma_active,
  output logic [15:0] dma_src_a,
  output logic        dma_src_rd,
  output logic [7:0]  oam_dma_a,
  output logic [7:0]  oam_dma_din,
  output logic        oam_dma_wr
);

  localparam int SW = (DMA_STRIDE > 2) ? $clog2(DMA_STRIDE) : 1;
  localparam logic [SW-1:0] STRIDE_LAST = SW'(DMA_STRIDE - 1);
  localparam logic [7:0]    LEN_LAST    = 8'(DMA_LEN - 1);

  dma_state_t    state;
  logic [7:0]    base;
  logic [7:0]    idx;
  logic [7:0]    idx_next;
  logic [SW-1:0] stride;

  assign idx_next = idx + 8'd1;

  // Source data arrives the clock after the read strobe, so it is passed
  // straight through while the write strobe is up.
  assign oam_dma_din = oam_dma_wr ? dma_src_din : 8'h00;

  // DMA FSM; a start request always wins and restarts from byte 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DMA_IDLE;
      base       <= 8'h00;
      idx        <= 8'h00;
      stride     <= '0;
      dma_active <= 1'b0;
      dma_src_a  <= 16'h0000;
      dma_src_rd <= 1'b0;
      oam_dma_a  <= 8'h00;
      oam_dma_wr <= 1'b0;
    end else if (start) begin
      state      <= DMA_READ;
      base       <= src_page;
      idx        <= 8'h00;
      stride     <= '0;
      dma_active <= 1'b1;
      dma_src_a  <= {src_page, 8'h00};
      dma_src_rd <= 1'b1;
      oam_dma_wr <= 1'b0;
    end else begin
      case (state)
        DMA_READ: begin
          state      <= DMA_WRITE;
          stride     <= SW'(1);
          dma_src_rd <= 1'b0;
          oam_dma_a  <= idx;
          oam_dma_wr <= 1'b1;
        end
        DMA_WRITE: begin
          oam_dma_wr <= 1'b0;
          if (stride == STRIDE_LAST) begin
            if (idx == LEN_LAST) begin
              state      <= DMA_IDLE;
              dma_active <= 1'b0;
            end else begin
              state      <= DMA_READ;
              idx        <= idx_next;
              stride     <= '0;
              dma_src_a  <= {base, idx_next};
              dma_src_rd <= 1'b1;
            end
          end else begin
            stride <= stride + SW'(1);
          end
        end
        default: begin
          dma_src_rd <= 1'b0;
          oam_dma_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ppu_mmio_regs.sv
// PPU MMIO register window 0xFF40-0xFF4B: register file, read-back,
// STAT/VBlank interrupt generation and the OAM DMA trigger.
module ppu_mmio_regs
  import ppu_pkg::*;
#(
  parameter int DMA_STRIDE = 4,
  parameter int DMA_LEN    = 160
) (
  input  logic               clk,
  input  logic               rst_n,
  ppu_mmio_regs_if.slave     bus,
  input  logic [1:0]         ppu_mode,
  input  logic [7:0]         ppu_ly,
  output logic [7:0]         lcdc,
  output logic [7:0]         scy,
  output logic [7:0]         scx,
  output logic [7:0]         lyc,
  output logic [7:0]         bgp,
  output logic [7:0]         obp0,
  output logic [7:0]         obp1,
  output logic [7:0]         wy,
  output logic [7:0]         wx,
  output logic               irq_vblank,
  output logic               irq_stat,
  output logic               dma_active,
  output logic [15:0]        dma_src_a,
  output logic               dma_src_rd,
  input  logic [7:0]         dma_src_din,
  output logic [7:0]         oam_dma_a,
  output logic [7:0]         oam_dma_din,
  output logic               oam_dma_wr
);

  ppu_mode_t  mode;
  ppu_mode_t  mode_q;
  logic [3:0] stat_en;     // STAT bits 6:3
  logic [7:0] dma_reg;
  logic       coinc;
  logic       stat_line;
  logic       stat_line_q;
  logic       dma_start;
  logic [7:0] rd_data;

  assign mode      = ppu_mode_t'(ppu_mode);
  assign dma_start = bus.mmio_wr && (bus.mmio_a == ADDR_DMA);

  // The line uses the live LY/LYC compare so irq_stat lands one clock after
  // the cause, in step with the registered coincidence flag.
  assign stat_line = (stat_en[3] && (ppu_ly == lyc))
                   | (stat_en[2] && (mode == OAM_SCAN))
                   | (stat_en[1] && (mode == VBLANK))
                   | (stat_en[0] && (mode == HBLANK));

  // Register writes from the CPU; LY is read-only and unmapped addresses are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcdc    <= RST_LCDC;
      stat_en <= 4'h0;
      scy     <= RST_REG;
      scx     <= RST_REG;
      lyc     <= RST_REG;
      dma_reg <= RST_REG;
      bgp     <= RST_BGP;
      obp0    <= RST_REG;
      obp1    <= RST_REG;
      wy      <= RST_REG;
      wx      <= RST_REG;
    end else if (bus.mmio_wr) begin
      case (bus.mmio_a)
        ADDR_LCDC: lcdc    <= bus.mmio_din;
        ADDR_STAT: stat_en <= bus.mmio_din[6:3];
        ADDR_SCY:  scy     <= bus.mmio_din;
        ADDR_SCX:  scx     <= bus.mmio_din;
        ADDR_LYC:  lyc     <= bus.mmio_din;
        ADDR_DMA:  dma_reg <= bus.mmio_din;
        ADDR_BGP:  bgp     <= bus.mmio_din;
        ADDR_OBP0: obp0    <= bus.mmio_din;
        ADDR_OBP1: obp1    <= bus.mmio_din;
        ADDR_WY:   wy      <= bus.mmio_din;
        ADDR_WX:   wx      <= bus.mmio_din;
        default: ;
      endcase
    end
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_data = RST_DOUT;
    case (bus.mmio_a)
      ADDR_LCDC: rd_data = lcdc;
      ADDR_STAT: rd_data = {1'b1, stat_en, coinc, ppu_mode};
      ADDR_SCY:  rd_data = scy;
      ADDR_SCX:  rd_data = scx;
      ADDR_LY:   rd_data = ppu_ly;
      ADDR_LYC:  rd_data = lyc;
      ADDR_DMA:  rd_data = dma_reg;
      ADDR_BGP:  rd_data = bgp;
      ADDR_OBP0: rd_data = obp0;
      ADDR_OBP1: rd_data = obp1;
      ADDR_WY:   rd_data = wy;
      ADDR_WX:   rd_data = wx;
      default: ;
    endcase
  end

  // One-clock registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.mmio_dout <= RST_DOUT;
    else        bus.mmio_dout <= rd_data;
  end

  // Coincidence flag plus rising-edge detection for STAT and VBlank interrupts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coinc       <= 1'b0;
      stat_line_q <= 1'b0;
      irq_stat    <= 1'b0;
      mode_q      <= HBLANK;
      irq_vblank  <= 1'b0;
    end else begin
      coinc       <= (ppu_ly == lyc);
      stat_line_q <= stat_line;
      irq_stat    <= stat_line && !stat_line_q;
      mode_q      <= mode;
      irq_vblank  <= (mode == VBLANK) && (mode_q != VBLANK);
    end
  end

  ppu_oam_dma #(
    .DMA_STRIDE (DMA_STRIDE),
    .DMA_LEN    (DMA_LEN)
  ) u_dma (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (dma_start),
    .src_page    (bus.mmio_din),
    .dma_src_din (dma_src_din),
    .dma_active  (dma_active),
    .dma_src_a   (dma_src_a),
    .dma_src_rd  (dma_src_rd),
    .oam_dma_a   (oam_dma_a),
    .oam_dma_din (oam_dma_din),
    .oam_dma_wr  (oam_dma_wr)
  );

endmodule
